// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- load/store unit controller for the MEM stage of an RV32I core.
//
// Accepts one load or store at a time, checks it (illegal funct3, misalignment,
// data-memory range), drives a single-cycle access to an asynchronous-read
// data memory, and returns either an extended load result / store-done pulse
// or a fault pulse.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/_ready  request handshake; accepted when both are high
//   req_write         1 = store, 0 = load
//   req_funct3        RV32I load/store funct3
//   req_addr          effective byte address
//   req_wdata         store data, right-aligned
//   flush             kills the in-flight access
//   stall             pipeline hold
//   dm_we/_mode/_addr/_wdata  data-memory write port (mode 000 b, 001 h, 010 w)
//   dm_rdata          data-memory asynchronous read data
//   rsp_valid/_data   one-cycle response pulse with extended load data
//   fault/_cause/_addr one-cycle fault pulse, cause (01 misaligned,
//                     10 out of range, 11 illegal funct3), last fault address
// ---------------------------------------------------------------------------
module lsu_ctrl #(
   parameter int unsigned DM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   output logic        req_ready,
   output logic        stall,
   output logic        dm_we,
   output logic [2:0]  dm_mode,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_addr
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_RANGE    = 2'b10;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] fault_addr_q, fault_addr_d;

   logic        accept;
   logic        illegal, misaligned, out_of_range;
   logic [2:0]  size;
   logic [32:0] end_addr;
   logic [1:0]  cause_chk;

   // Request checks, evaluated on the live request inputs in IDLE.
   always_comb begin
      illegal = req_write ? (req_funct3 > 3'b010)
                          : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
      case (req_funct3[1:0])
         2'b00:   size = 3'd1;
         2'b01:   size = 3'd2;
         default: size = 3'd4;
      endcase
      misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
      // 33-bit sum so an access near 0xFFFFFFFF cannot wrap back into range.
      end_addr     = {1'b0, req_addr} + {30'd0, size};
      out_of_range = end_addr > 33'(DM_BYTES);
      if (illegal)           cause_chk = CAUSE_ILLEGAL;
      else if (misaligned)   cause_chk = CAUSE_MISALIGN;
      else if (out_of_range) cause_chk = CAUSE_RANGE;
      else                   cause_chk = CAUSE_NONE;
   end

   assign req_ready = (state_q == IDLE) && !flush;
   assign accept    = req_ready && req_valid;

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      cause_d      = cause_q;
      fault_addr_d = fault_addr_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               write_d  = req_write;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               cause_d  = cause_chk;
               state_d  = (cause_chk != CAUSE_NONE) ? FAULT : ACCESS;
            end
         end
         ACCESS: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               rdata_d = dm_rdata;
               state_d = RESP;
            end
         end
         RESP: state_d = IDLE;
         FAULT: begin
            if (!flush) fault_addr_d = addr_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         funct3_q     <= 3'b000;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         rdata_q      <= 32'd0;
         cause_q      <= 2'b00;
         fault_addr_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         cause_q      <= cause_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   // Memory port: the registered fields are always visible, only dm_we acts.
   assign dm_we    = (state_q == ACCESS) && write_q && !flush;
   assign dm_addr  = addr_q;
   assign dm_mode  = {1'b0, funct3_q[1:0]};
   assign dm_wdata = wdata_q;

   // RESP and FAULT release the pipeline so it advances with the result.
   assign stall = (state_q == ACCESS) || (state_q == IDLE && req_valid);

   assign rsp_valid = (state_q == RESP) && !flush;

   // Extension looks only at the low bits, whatever the memory put above them.
   always_comb begin
      rsp_data = 32'd0;
      if (!write_q) begin
         case (funct3_q)
            3'b000:  rsp_data = {{24{rdata_q[7]}}, rdata_q[7:0]};
            3'b001:  rsp_data = {{16{rdata_q[15]}}, rdata_q[15:0]};
            3'b100:  rsp_data = {24'd0, rdata_q[7:0]};
            3'b101:  rsp_data = {16'd0, rdata_q[15:0]};
            default: rsp_data = rdata_q;
         endcase
      end
   end

   assign fault       = (state_q == FAULT) && !flush;
   assign fault_cause = cause_q;
   // Show the new address during the pulse itself; the register holds it after.
   assign fault_addr  = fault ? addr_q : fault_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

   typedef struct {
      logic        write;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [1:0]  cause;   // 0 = access expected to succeed
      logic [31:0] exp;     // expected rsp_data
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_write, flush;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata, dm_rdata;
   logic        req_ready, stall, dm_we, rsp_valid, fault;
   logic [2:0]  dm_mode;
   logic [31:0] dm_addr, dm_wdata, rsp_data, fault_addr;
   logic [1:0]  fault_cause;

   int n_pass   = 0;
   int n_total  = 0;
   int we_count = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(.DM_BYTES(1024)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
      .req_ready(req_ready), .stall(stall),
      .dm_we(dm_we), .dm_mode(dm_mode), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr)
   );

   always @(posedge clk) if (dm_we) we_count <= we_count + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive_req(input logic w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
   endtask

   // Full transaction from an IDLE negedge to the IDLE negedge after it.
   task automatic run_vec(input int i, input vec_t v);
      int we0;
      @(negedge clk);
      we0 = we_count;
      drive_req(v.write, v.f3, v.addr, v.wdata);
      dm_rdata = v.rdata;
      #1;
      check($sformatf("v%0d req_ready", i), {31'd0, req_ready}, 32'd1);
      check($sformatf("v%0d stall_idle", i), {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      if (v.cause == 2'b00) begin
         check($sformatf("v%0d dm_we", i), {31'd0, dm_we}, {31'd0, v.write});
         check($sformatf("v%0d dm_addr", i), dm_addr, v.addr);
         check($sformatf("v%0d dm_mode", i), {29'd0, dm_mode}, {30'd0, v.f3[1:0]});
         if (v.write) check($sformatf("v%0d dm_wdata", i), dm_wdata, v.wdata);
         check($sformatf("v%0d stall_access", i), {31'd0, stall}, 32'd1);
         @(negedge clk);
         check($sformatf("v%0d rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
         check($sformatf("v%0d rsp_data", i), rsp_data, v.exp);
         check($sformatf("v%0d stall_resp", i), {31'd0, stall}, 32'd0);
      end else begin
         check($sformatf("v%0d fault", i), {31'd0, fault}, 32'd1);
         check($sformatf("v%0d fault_cause", i), {30'd0, fault_cause}, {30'd0, v.cause});
         check($sformatf("v%0d fault_addr", i), fault_addr, v.addr);
         check($sformatf("v%0d rsp_valid_fault", i), {31'd0, rsp_valid}, 32'd0);
         check($sformatf("v%0d dm_we_fault", i), {31'd0, dm_we}, 32'd0);
      end
      @(negedge clk);
      check($sformatf("v%0d back_idle", i), {31'd0, req_ready}, 32'd1);
      check($sformatf("v%0d no_pulse", i), {31'd0, rsp_valid | fault}, 32'd0);
      check($sformatf("v%0d writes", i), 32'(we_count - we0),
            (v.write && v.cause == 2'b00) ? 32'd1 : 32'd0);
   endtask

   vec_t vecs[16];

   initial begin
      int we0;
      vecs[0]  = '{1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 32'hFFFFFFFF, 2'b00, 32'h0};
      vecs[1]  = '{1'b0, 3'b000, 32'h10,       32'h0,        32'h000000EF, 2'b00, 32'hFFFFFFEF};
      vecs[2]  = '{1'b0, 3'b100, 32'h10,       32'h0,        32'h000000EF, 2'b00, 32'h000000EF};
      vecs[3]  = '{1'b0, 3'b001, 32'h12,       32'h0,        32'h00008001, 2'b00, 32'hFFFF8001};
      vecs[4]  = '{1'b0, 3'b101, 32'h12,       32'h0,        32'hFFFF8001, 2'b00, 32'h00008001};
      vecs[5]  = '{1'b0, 3'b010, 32'h3FC,      32'h0,        32'h12345678, 2'b00, 32'h12345678};
      vecs[6]  = '{1'b0, 3'b000, 32'h3FF,      32'h0,        32'hFFFFFF7F, 2'b00, 32'h0000007F};
      vecs[7]  = '{1'b0, 3'b001, 32'h11,       32'h0,        32'h0,        2'b01, 32'h0};
      vecs[8]  = '{1'b1, 3'b010, 32'h12,       32'h1,        32'h0,        2'b01, 32'h0};
      vecs[9]  = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        2'b10, 32'h0};
      vecs[10] = '{1'b0, 3'b000, 32'h400,      32'h0,        32'h0,        2'b10, 32'h0};
      vecs[11] = '{1'b0, 3'b001, 32'h3FF,      32'h0,        32'h0,        2'b01, 32'h0};
      vecs[12] = '{1'b0, 3'b011, 32'h10,       32'h0,        32'h0,        2'b11, 32'h0};
      vecs[13] = '{1'b0, 3'b110, 32'h11,       32'h0,        32'h0,        2'b11, 32'h0};
      vecs[14] = '{1'b1, 3'b100, 32'h10,       32'h0,        32'h0,        2'b11, 32'h0};
      vecs[15] = '{1'b1, 3'b001, 32'h3FE,      32'h0000BEEF, 32'h0,        2'b00, 32'h0};

      rst = 1'b1; flush = 1'b0; dm_rdata = 32'd0;
      drive_req(1'b0, 3'b000, 32'd0, 32'd0);
      req_valid = 1'b0;
      #12;
      check("rst dm_we", {31'd0, dm_we}, 32'd0);
      check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst rsp_data", rsp_data, 32'd0);
      check("rst fault", {31'd0, fault}, 32'd0);
      check("rst fault_cause", {30'd0, fault_cause}, 32'd0);
      check("rst fault_addr", fault_addr, 32'd0);
      check("rst dm_addr", dm_addr, 32'd0);
      check("rst stall", {31'd0, stall}, 32'd0);
      check("rst req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

      // Back-to-back: requests ignored outside IDLE, accepted right after RESP.
      @(negedge clk);
      drive_req(1'b0, 3'b010, 32'h20, 32'd0);
      dm_rdata = 32'hCAFEF00D;
      #1 check("b2b ready0", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_addr = 32'h40;
      #1 check("b2b ready_access", {31'd0, req_ready}, 32'd0);
      check("b2b addr_held", dm_addr, 32'h20);
      @(negedge clk);
      check("b2b rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("b2b rsp_data", rsp_data, 32'hCAFEF00D);
      check("b2b ready_resp", {31'd0, req_ready}, 32'd0);
      req_funct3 = 3'b000;
      dm_rdata   = 32'h00000080;
      @(negedge clk);
      check("b2b ready_idle", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b addr2", dm_addr, 32'h40);
      check("b2b mode2", {29'd0, dm_mode}, 32'd0);
      @(negedge clk);
      check("b2b rsp_data2", rsp_data, 32'hFFFFFF80);

      // Flush during ACCESS of a store: no write, straight back to IDLE.
      @(negedge clk);
      we0 = we_count;
      drive_req(1'b1, 3'b000, 32'h30, 32'h55);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      #1 check("flush_acc dm_we", {31'd0, dm_we}, 32'd0);
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_acc idle", {31'd0, req_ready}, 32'd1);
      check("flush_acc no_rsp", {31'd0, rsp_valid}, 32'd0);
      check("flush_acc writes", 32'(we_count - we0), 32'd0);

      // Flush during RESP suppresses the response.
      drive_req(1'b0, 3'b010, 32'h34, 32'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1 check("flush_resp rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_resp idle", {31'd0, req_ready}, 32'd1);

      // Flush during FAULT suppresses the pulse and keeps the old fault address.
      drive_req(1'b0, 3'b010, 32'h35, 32'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      #1 check("flush_fault fault", {31'd0, fault}, 32'd0);
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_fault addr_kept", fault_addr, 32'h10);
      check("flush_fault idle", {31'd0, req_ready}, 32'd1);

      // Flush in IDLE blocks acceptance.
      drive_req(1'b1, 3'b010, 32'h38, 32'h1);
      flush = 1'b1;
      #1 check("flush_idle ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1 begin req_valid = 1'b0; flush = 1'b0; end
      @(negedge clk);
      check("flush_idle still_idle", {31'd0, req_ready}, 32'd1);
      check("flush_idle stall", {31'd0, stall}, 32'd0);

      // Reset in the middle of a store ACCESS.
      we0 = we_count;
      drive_req(1'b1, 3'b010, 32'h44, 32'h11223344);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rst_acc we_before", {31'd0, dm_we}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_acc dm_we", {31'd0, dm_we}, 32'd0);
      check("rst_acc dm_addr", dm_addr, 32'd0);
      check("rst_acc dm_wdata", dm_wdata, 32'd0);
      check("rst_acc rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_acc stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      check("rst_acc writes", 32'(we_count - we0), 32'd0);
      check("rst_acc no_rsp", {31'd0, rsp_valid}, 32'd0);
      run_vec(100, '{1'b0, 3'b010, 32'h48, 32'h0, 32'h0BADF00D, 2'b00, 32'h0BADF00D});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
